// File: rtl/riscv_pkg.sv
// Shared RV32I constants, FSM state codes and ALU encoding for the multi-cycle core.
// Pure declarations: no latency, no flow control.
package riscv_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;
    localparam logic [2:0] F3_WORD = 3'b010;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_FETCH = 3'd1;
    localparam state_t ST_EXEC  = 3'd2;
    localparam state_t ST_MEM   = 3'd3;
    localparam state_t ST_HALT  = 3'd4;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR,  ALU_AND
    } alu_op_e;

    // The alt bit selects SUB only for register-register ops; OP-IMM has no SUBI.
    function automatic alu_op_e alu_sel(input logic [2:0] f3, input logic alt, input logic is_reg);
        alu_op_e op;
        case (f3)
            F3_ADD:  op = (alt && is_reg) ? ALU_SUB : ALU_ADD;
            F3_SLL:  op = ALU_SLL;
            F3_SLT:  op = ALU_SLT;
            F3_SLTU: op = ALU_SLTU;
            F3_XOR:  op = ALU_XOR;
            F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
            F3_OR:   op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    function automatic logic [31:0] alu_calc(input alu_op_e op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] y;
        case (op)
            ALU_ADD:  y = a + b;
            ALU_SUB:  y = a - b;
            ALU_SLL:  y = a << b[4:0];
            ALU_SLT:  y = {31'b0, $signed(a) < $signed(b)};
            ALU_SLTU: y = {31'b0, a < b};
            ALU_XOR:  y = a ^ b;
            ALU_SRL:  y = a >> b[4:0];
            ALU_SRA:  y = 32'($signed(a) >>> b[4:0]);
            ALU_OR:   y = a | b;
            ALU_AND:  y = a & b;
            default:  y = '0;
        endcase
        return y;
    endfunction

endpackage

// File: rtl/riscv_multi_cycle_if.sv
// Single-ported memory bus: one request held until mem_ready, one transfer per request.
// The slave stalls the core simply by holding mem_ready low.
interface riscv_multi_cycle_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    modport master (output mem_req, mem_we, mem_addr, mem_wdata, input  mem_rdata, mem_ready);
    modport slave  (input  mem_req, mem_we, mem_addr, mem_wdata, output mem_rdata, mem_ready);
endinterface

// File: rtl/riscv_regfile.sv
// Integer register file: two asynchronous read ports, one synchronous write port, x0 hardwired to 0.
// Out-of-range indices read 0 and are never written; the core halts on them anyway.
module riscv_regfile #(
    parameter int NREGS = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic [31:0] rd1,
    output logic [31:0] rd2,
    input  logic        we,
    input  logic [4:0]  wa,
    input  logic [31:0] wd
);
    localparam int         AW      = $clog2(NREGS);
    localparam logic [5:0] NREGS_W = 6'(NREGS);

    logic [31:0] regs_q [NREGS];
    logic [31:0] regs_d [NREGS];

    always_comb begin
        regs_d = regs_q;
        if (we && wa != 5'd0 && {1'b0, wa} < NREGS_W) begin
            regs_d[wa[AW-1:0]] = wd;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    assign rd1 = (ra1 != 5'd0 && {1'b0, ra1} < NREGS_W) ? regs_q[ra1[AW-1:0]] : '0;
    assign rd2 = (ra2 != 5'd0 && {1'b0, ra2} < NREGS_W) ? regs_q[ra2[AW-1:0]] : '0;
endmodule

// File: rtl/riscv_multi_cycle.sv
// Multi-cycle RV32I word-subset core: FETCH/EXEC (+MEM for LW/SW), CPI 2 on zero-wait memory.
// Each bus request is held stable until mem_ready; any fault parks the core in HALT until reset.
module riscv_multi_cycle
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          NREGS    = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    riscv_multi_cycle_if.master bus,
    output logic [31:0]         pc_out,
    output logic [31:0]         instr_out,
    output logic                retire,
    output logic                halted
);
    localparam logic [5:0] NREGS_W = 6'(NREGS);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d, ir_q, ir_d, addr_q, addr_d;

    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] rs1_v, rs2_v, alu_y, pc4;
    logic [31:0] wb_val, target, ea;
    logic        legal, use_rs1, use_rs2, use_rd, is_mem, redirect, fault;
    logic        rf_we;
    logic [31:0] rf_wd;

    assign opcode = ir_q[6:0];
    assign rd     = ir_q[11:7];
    assign funct3 = ir_q[14:12];
    assign rs1    = ir_q[19:15];
    assign rs2    = ir_q[24:20];
    assign funct7 = ir_q[31:25];
    assign imm_i  = {{20{ir_q[31]}}, ir_q[31:20]};
    assign imm_s  = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
    assign imm_b  = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
    assign imm_u  = {ir_q[31:12], 12'b0};
    assign imm_j  = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
    assign pc4    = pc_q + 32'd4;

    riscv_regfile #(.NREGS(NREGS)) u_regfile (
        .clk (clk), .rst_n (rst_n),
        .ra1 (rs1), .ra2 (rs2), .rd1 (rs1_v), .rd2 (rs2_v),
        .we  (rf_we), .wa (rd), .wd (rf_wd)
    );

    assign alu_y = alu_calc(alu_sel(funct3, funct7[5], opcode == OPC_OP), rs1_v,
                            (opcode == OPC_OP) ? rs2_v : imm_i);

    always_comb begin
        legal = 1'b0; use_rs1 = 1'b0; use_rs2 = 1'b0; use_rd = 1'b0;
        is_mem = 1'b0; redirect = 1'b0;
        wb_val = '0; target = '0; ea = '0;
        case (opcode)
            OPC_OP: begin
                legal  = (funct7 == F7_BASE) || (funct7 == F7_ALT && (funct3 == F3_ADD || funct3 == F3_SR));
                use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1;
                wb_val = alu_y;
            end
            OPC_OPIMM: begin
                legal  = (funct3 == F3_SLL) ? (funct7 == F7_BASE) :
                         (funct3 == F3_SR)  ? (funct7 == F7_BASE || funct7 == F7_ALT) : 1'b1;
                use_rs1 = 1'b1; use_rd = 1'b1;
                wb_val = alu_y;
            end
            OPC_LUI:   begin legal = 1'b1; use_rd = 1'b1; wb_val = imm_u; end
            OPC_AUIPC: begin legal = 1'b1; use_rd = 1'b1; wb_val = pc_q + imm_u; end
            OPC_JAL: begin
                legal = 1'b1; use_rd = 1'b1; redirect = 1'b1;
                wb_val = pc4; target = pc_q + imm_j;
            end
            OPC_JALR: begin
                legal = (funct3 == 3'b000); use_rs1 = 1'b1; use_rd = 1'b1; redirect = 1'b1;
                wb_val = pc4; target = (rs1_v + imm_i) & ~32'd1;
            end
            OPC_BRANCH: begin
                legal = (funct3 != 3'b010) && (funct3 != 3'b011);
                use_rs1 = 1'b1; use_rs2 = 1'b1;
                target = pc_q + imm_b;
                case (funct3)
                    F3_BEQ:  redirect = (rs1_v == rs2_v);
                    F3_BNE:  redirect = (rs1_v != rs2_v);
                    F3_BLT:  redirect = ($signed(rs1_v) <  $signed(rs2_v));
                    F3_BGE:  redirect = ($signed(rs1_v) >= $signed(rs2_v));
                    F3_BLTU: redirect = (rs1_v <  rs2_v);
                    F3_BGEU: redirect = (rs1_v >= rs2_v);
                    default: redirect = 1'b0;
                endcase
            end
            OPC_LOAD: begin
                legal = (funct3 == F3_WORD); use_rs1 = 1'b1; use_rd = 1'b1; is_mem = 1'b1;
                ea = rs1_v + imm_i;
            end
            OPC_STORE: begin
                legal = (funct3 == F3_WORD); use_rs1 = 1'b1; use_rs2 = 1'b1; is_mem = 1'b1;
                ea = rs1_v + imm_s;
            end
            default: legal = 1'b0;
        endcase
    end

    // Misalignment only faults a branch when it is actually taken.
    assign fault = !legal
                || (use_rs1 && {1'b0, rs1} >= NREGS_W)
                || (use_rs2 && {1'b0, rs2} >= NREGS_W)
                || (use_rd  && {1'b0, rd}  >= NREGS_W)
                || (is_mem && ea[1:0] != 2'b00)
                || (redirect && target[1:0] != 2'b00);

    always_comb begin
        state_d = state_q; pc_d = pc_q; ir_d = ir_q; addr_d = addr_q;
        rf_we = 1'b0; rf_wd = '0; retire = 1'b0;
        case (state_q)
            ST_IDLE:  state_d = ST_FETCH;
            ST_FETCH: begin
                if (bus.mem_ready) begin
                    ir_d    = bus.mem_rdata;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (fault) begin
                    state_d = ST_HALT;
                end else if (is_mem) begin
                    addr_d  = ea;
                    state_d = ST_MEM;
                end else begin
                    rf_we   = use_rd;
                    rf_wd   = wb_val;
                    pc_d    = redirect ? target : pc4;
                    retire  = 1'b1;
                    state_d = ST_FETCH;
                end
            end
            ST_MEM: begin
                if (bus.mem_ready) begin
                    rf_we   = (opcode == OPC_LOAD);
                    rf_wd   = bus.mem_rdata;
                    pc_d    = pc4;
                    retire  = 1'b1;
                    state_d = ST_FETCH;
                end
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_HALT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            addr_q  <= addr_d;
        end
    end

    assign bus.mem_req   = (state_q == ST_FETCH) || (state_q == ST_MEM);
    assign bus.mem_we    = (state_q == ST_MEM) && (opcode == OPC_STORE);
    assign bus.mem_addr  = (state_q == ST_MEM) ? addr_q : pc_q;
    assign bus.mem_wdata = rs2_v;
    assign pc_out        = pc_q;
    assign instr_out     = ir_q;
    assign halted        = (state_q == ST_HALT);
endmodule

// File: doc/riscv_multi_cycle.md
RISCV_MULTI_CYCLE -- requirements
Module: riscv_multi_cycle

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, address of the first fetch after reset.
REQ-002 Parameter NREGS, default 32, register count: 32 (RV32I) or 16 (RV32E); other values are illegal.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-005 mem_req  output  1  memory request valid.
REQ-006 mem_we  output  1  1 = store, 0 = fetch/load.
REQ-007 mem_addr  output  32  word-aligned byte address.
REQ-008 mem_wdata  output  32  store data.
REQ-009 mem_rdata  input  32  read data, valid in the mem_ready cycle.
REQ-010 mem_ready  input  1  transfer completes in any cycle with mem_req=1 and mem_ready=1.
REQ-011 pc_out  output  32  PC of the instruction in progress.
REQ-012 instr_out  output  32  latched instruction register.
REQ-013 retire  output  1  one-cycle pulse per completed instruction.
REQ-014 halted  output  1  sticky fault flag.

Function
REQ-015 FSM states: IDLE, FETCH, EXEC, MEM, HALT; IDLE always advances to FETCH after one cycle.
REQ-016 FETCH: mem_req=1, mem_we=0, mem_addr=pc; on mem_ready, latch mem_rdata into instr_out and go to EXEC.
REQ-017 mem_addr, mem_we and mem_wdata stay stable from request until mem_ready; exactly one transfer occurs per request.
REQ-018 EXEC decodes and executes RV32I word subset: OP, OP-IMM, LUI, AUIPC, JAL, JALR, BRANCH (all six), LW, SW.
REQ-019 For non-memory instructions, EXEC writes rd, updates pc (pc+4, branch/jump target) and pulses retire in the same cycle, then goes to FETCH; CPI = 2 with zero-wait memory.
REQ-020 LW/SW: EXEC computes rs1+imm and goes to MEM; MEM issues the request (SW: mem_we=1, mem_wdata=rs2); on mem_ready, LW writes mem_rdata to rd, pc += 4, retire pulses, then FETCH.
REQ-021 Writes to x0 are discarded; x0 always reads 0.
REQ-022 JAL/JALR write pc+4 to rd; JALR target = (rs1+imm) with bit 0 cleared, using rs1 sampled before the rd write (rd==rs1 safe).
REQ-023 Branches use signed compares for BLT/BGE and unsigned for BLTU/BGEU; taken target = pc+B-imm.
REQ-024 All arithmetic is 32-bit modulo 2^32; shift amounts use the low 5 bits.
REQ-025 Go to HALT, with no register write and no pc update, on: unknown opcode/funct; rs1/rs2/rd index >= NREGS; LW/SW address[1:0] != 0 (no memory request issued); taken branch/jump target[1:0] != 0.
REQ-026 HALT: halted=1 and mem_req=0 until reset.
REQ-027 retire=0 in every state except the completing cycle of an instruction.

Reset
REQ-028 On rst_n=0 at a clock edge, the block enters IDLE with pc=RESET_PC, instr_out=0, all registers=0, mem_req=0, mem_we=0, retire=0 and halted=0.
REQ-029 Reset during an outstanding request abandons it; mem_req is 0 from the next cycle onward.

Structure
REQ-030 Shared package riscv_pkg holds the opcode/funct constants, the FSM state enum and the ALU operation encoding.
REQ-031 One sub-module, riscv_regfile (parameter NREGS), with 2 asynchronous read ports and 1 synchronous write port.

Verification
REQ-032 Reset with RESET_PC=0x100: mem_req=0 in IDLE; next cycle mem_req=1, mem_addr=0x100, mem_we=0.
REQ-033 addi x1,x0,5; addi x2,x1,-7 with zero-wait memory: x2=0xFFFFFFFE, retire every 2 cycles, pc=0x108 after both.
REQ-034 sw x2,8(x0) with mem_ready low for 3 cycles: mem_addr=0x8, mem_we=1, mem_wdata=0xFFFFFFFE held 4 cycles; one transfer, then FETCH.
REQ-035 Branch compares with x1=5, x2=0xFFFFFFFE: blt x2,x1 is taken (pc=pc+imm); bltu x2,x1 is not taken (pc+4).
REQ-036 jalr x1,0(x1) with x1=0x21 at pc=0x10: x1=0x14, pc=0x20.
REQ-037 Instruction 0x00000000 gives halted=1 next cycle and mem_req=0 thereafter; lw x3,6(x0) halts with no memory request.
